// File: rtl/jtag_byte_loader.sv
// Parses JTAG host bytes into framed commands and turns WRITE payloads into sequential memory word writes.
// Optional trailing XOR checksum per WRITE frame when JTAG_LOADER_CHECKSUM_EN is defined.
module jtag_byte_loader #(
  parameter int ADDR_W = 16,
  parameter int WORD_W = 32
) (
  input  logic              tck,
  input  logic              aclr,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_ready,
  output logic              start,
  output logic              busy,
  output logic [2:0]        err
);

  // state | meaning
  // IDLE  | waiting for an opcode byte
  // AHI   | expecting address high byte
  // ALO   | expecting address low byte
  // LEN   | expecting word count (0 = 256)
  // DATA  | collecting payload bytes into words
  // CHK   | expecting trailing checksum byte (checksum build only)

  localparam int BPW = WORD_W / 8;
  localparam int BCW = (BPW > 1) ? $clog2(BPW) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_AHI,
    S_ALO,
    S_LEN,
    S_DATA
`ifdef JTAG_LOADER_CHECKSUM_EN
    , S_CHK
`endif
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_addr_hi;
  logic [ADDR_W-1:0]   r_waddr;
  logic [8:0]          r_words_left;
  logic [BCW-1:0]      r_byte_cnt;
  logic [WORD_W-1:0]   r_asm;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WORD_W-1:0]   r_mem_wdata;
  logic                r_start;
  logic [1:0]          r_err;

  logic                w_bad_op;
  logic                w_clear;
  logic                w_start_cmd;
  logic                w_complete;
  logic                w_ovf;
  logic                w_load;
  logic [WORD_W-1:0]   w_word;

`ifdef JTAG_LOADER_CHECKSUM_EN
  logic [7:0]          r_csum;
  logic                r_chk_err;
  logic                w_chk_err;
`endif

  // Shift-right assembly: after BPW bytes the first byte sits in [7:0].
  assign w_word = WORD_W'({byte_in, r_asm} >> 8);

  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_bad_op    = 1'b0;
    w_clear     = 1'b0;
    w_start_cmd = 1'b0;
    w_complete  = 1'b0;
`ifdef JTAG_LOADER_CHECKSUM_EN
    w_chk_err   = 1'b0;
`endif
    if (byte_valid) begin
      case (r_state)
        S_IDLE: begin
          case (byte_in)
            8'h00:   ;
            8'hA5:   w_state_nxt = S_AHI;
            8'h5A:   w_start_cmd = 1'b1;
            8'hC3:   w_clear     = 1'b1;
            default: w_bad_op    = 1'b1;
          endcase
        end
        S_AHI: w_state_nxt = S_ALO;
        S_ALO: w_state_nxt = S_LEN;
        S_LEN: w_state_nxt = S_DATA;
        S_DATA: begin
          if (r_byte_cnt == '0) begin
            w_complete = 1'b1;
            if (r_words_left == 9'd1) begin
`ifdef JTAG_LOADER_CHECKSUM_EN
              w_state_nxt = S_CHK;
`else
              w_state_nxt = S_IDLE;
`endif
            end
          end
        end
`ifdef JTAG_LOADER_CHECKSUM_EN
        S_CHK: begin
          w_chk_err   = (byte_in != r_csum);
          w_state_nxt = S_IDLE;
        end
`endif
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  // A completing word loads if the output slot is free or being accepted this edge.
  assign w_ovf  = w_complete && r_mem_we && !mem_ready;
  assign w_load = w_complete && !w_ovf;

  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      r_addr_hi    <= '0;
      r_waddr      <= '0;
      r_words_left <= '0;
      r_byte_cnt   <= '0;
      r_asm        <= '0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_start      <= 1'b0;
      r_err        <= '0;
    end else begin
      if (byte_valid && r_state == S_AHI) r_addr_hi <= byte_in;
      if (byte_valid && r_state == S_ALO) r_waddr <= ADDR_W'({r_addr_hi, byte_in});
      if (byte_valid && r_state == S_LEN) begin
        r_words_left <= {(byte_in == 8'd0), byte_in};
        r_byte_cnt   <= BCW'(BPW - 1);
      end
      if (byte_valid && r_state == S_DATA) begin
        r_asm      <= w_word;
        r_byte_cnt <= (r_byte_cnt == '0) ? BCW'(BPW - 1) : r_byte_cnt - 1'b1;
      end
      // Dropped words still consume their address slot.
      if (w_complete) begin
        r_words_left <= r_words_left - 9'd1;
        r_waddr      <= r_waddr + 1'b1;
      end
      if (w_load) begin
        r_mem_we    <= 1'b1;
        r_mem_addr  <= r_waddr;
        r_mem_wdata <= w_word;
      end else if (r_mem_we && mem_ready) begin
        r_mem_we    <= 1'b0;
      end
      r_start <= w_start_cmd;
      r_err   <= (w_clear ? 2'b00 : r_err) | {w_ovf, w_bad_op};
    end
  end

`ifdef JTAG_LOADER_CHECKSUM_EN
  always_ff @(posedge tck or negedge aclr) begin
    if (!aclr) begin
      r_csum    <= '0;
      r_chk_err <= 1'b0;
    end else begin
      if (byte_valid && r_state == S_LEN)       r_csum <= '0;
      else if (byte_valid && r_state == S_DATA) r_csum <= r_csum ^ byte_in;
      r_chk_err <= (w_clear ? 1'b0 : r_chk_err) | w_chk_err;
    end
  end
  assign err = {r_chk_err, r_err};
`else
  assign err = {1'b0, r_err};
`endif

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign start     = r_start;
  assign busy      = (r_state != S_IDLE) || r_mem_we;

endmodule

// File: tb/tb_jtag_byte_loader.sv
// Self-checking bench for jtag_byte_loader: write scoreboard, command table, reset/overflow/wrap corner cases.
module tb_jtag_byte_loader;

  logic        tck = 1'b0;
  logic        aclr = 1'b0;
  logic [7:0]  byte_in = 8'h00;
  logic        byte_valid = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_we;
  logic [15:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        start;
  logic        busy;
  logic [2:0]  err;

  jtag_byte_loader #(.ADDR_W(16), .WORD_W(32)) dut (
    .tck(tck), .aclr(aclr), .byte_in(byte_in), .byte_valid(byte_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ready(mem_ready),
    .start(start), .busy(busy), .err(err)
  );

  always #5 tck = ~tck;

  typedef struct {
    logic [15:0] a;
    logic [31:0] d;
  } wr_t;

  typedef struct {
    logic [7:0] b;
    logic [2:0] err;
    logic       st;
  } cmd_t;

  wr_t        exp_q[$];
  logic [7:0] txq[$];
  int         n_chk = 0;
  int         n_fail = 0;
  int         n_wr = 0;
  bit         mon_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Write monitor: samples mid low phase, before the edge that accepts the write.
  logic        prev_pend = 1'b0;
  logic [15:0] prev_a;
  logic [31:0] prev_d;
  always @(negedge tck) begin
    wr_t e;
    #2;
    if (!mon_en) begin
      prev_pend = 1'b0;
    end else begin
      if (prev_pend) begin
        chk("hold_we", mem_we, 1'b1);
        chk("hold_addr", mem_addr, prev_a);
        chk("hold_data", mem_wdata, prev_d);
      end
      if (mem_we && mem_ready) begin
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_write: got addr %0h data %0h expected none", mem_addr, mem_wdata);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_addr, e.a);
          chk("wr_data", mem_wdata, e.d);
          n_wr++;
        end
      end
      prev_pend = mem_we && !mem_ready;
      prev_a    = mem_addr;
      prev_d    = mem_wdata;
    end
  end

  // Queue a WRITE frame; only the first n_exp words are expected to reach memory.
  task automatic build_write(input logic [15:0] addr, input int nw, input logic [7:0] base, input int n_exp);
    logic [7:0]  b;
    logic [7:0]  cs;
    logic [31:0] w;
    logic [15:0] a;
    txq.push_back(8'hA5);
    txq.push_back(addr[15:8]);
    txq.push_back(addr[7:0]);
    txq.push_back(nw[7:0]);
    cs = 8'h00;
    for (int wi = 0; wi < nw; wi++) begin
      w = 32'h0;
      for (int i = 0; i < 4; i++) begin
        b = base + 8'(wi * 4 + i);
        txq.push_back(b);
        cs = cs ^ b;
        w[8*i +: 8] = b;
      end
      a = addr + 16'(wi);
      if (wi < n_exp) exp_q.push_back('{a: a, d: w});
    end
`ifdef JTAG_LOADER_CHECKSUM_EN
    txq.push_back(cs);
`endif
  endtask

  task automatic flush(input bit b2b, input int ready_at);
    int i;
    i = 0;
    while (txq.size() > 0) begin
      @(negedge tck);
      if (i == ready_at) mem_ready = 1'b1;
      byte_in    = txq.pop_front();
      byte_valid = 1'b1;
      if (!b2b) begin
        @(negedge tck);
        byte_valid = 1'b0;
      end
      i++;
    end
    if (b2b) begin
      @(negedge tck);
      byte_valid = 1'b0;
    end
  endtask

  task automatic wait_drain();
    int t;
    t = 0;
    while ((busy !== 1'b0 || exp_q.size() != 0) && t < 200) begin
      @(negedge tck);
      t++;
    end
    chk("drain_in_time", (t < 200), 1'b1);
    chk("busy_low", busy, 1'b0);
  endtask

  task automatic send_cmd(input logic [7:0] b, input logic [2:0] e, input logic st);
    @(negedge tck);
    byte_in    = b;
    byte_valid = 1'b1;
    @(negedge tck);
    byte_valid = 1'b0;
    chk("cmd_start", start, st);
    chk("cmd_err", err, e);
    @(negedge tck);
    chk("cmd_start_off", start, 1'b0);
  endtask

  cmd_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{b: 8'h00, err: 3'b000, st: 1'b0};
    tbl[1] = '{b: 8'h7E, err: 3'b001, st: 1'b0};
    tbl[2] = '{b: 8'hC3, err: 3'b000, st: 1'b0};
    tbl[3] = '{b: 8'h5A, err: 3'b000, st: 1'b1};
    tbl[4] = '{b: 8'hFF, err: 3'b001, st: 1'b0};
    tbl[5] = '{b: 8'h5A, err: 3'b001, st: 1'b1};
    tbl[6] = '{b: 8'hC3, err: 3'b000, st: 1'b0};
    tbl[7] = '{b: 8'hA4, err: 3'b001, st: 1'b0};

    repeat (3) @(negedge tck);
    chk("rst_we", mem_we, 1'b0);
    chk("rst_addr", mem_addr, 16'h0);
    chk("rst_data", mem_wdata, 32'h0);
    chk("rst_start", start, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_err", err, 3'b000);
    aclr   = 1'b1;
    mon_en = 1'b1;

    // Basic two-word write, ready always high
    mem_ready = 1'b1;
    build_write(16'h0010, 2, 8'h01, 2);
    flush(1'b0, -1);
    wait_drain();
    chk("t1_writes", n_wr, 2);
    chk("t1_err", err, 3'b000);

    // Stalled memory, back-to-back bytes: second word overflows
    mem_ready = 1'b0;
    build_write(16'h0010, 2, 8'h01, 1);
    flush(1'b1, -1);
    repeat (3) @(negedge tck);
    chk("t2_err", err, 3'b010);
    chk("t2_we", mem_we, 1'b1);
    chk("t2_addr", mem_addr, 16'h0010);
    chk("t2_data", mem_wdata, 32'h04030201);
    chk("t2_busy", busy, 1'b1);
    send_cmd(8'h5A, 3'b010, 1'b1);
    mem_ready = 1'b1;
    wait_drain();
    chk("t2_writes", n_wr, 3);
    send_cmd(8'hC3, 3'b000, 1'b0);

    // Address wrap
    build_write(16'hFFFF, 2, 8'h30, 2);
    flush(1'b1, -1);
    wait_drain();
    chk("t3_writes", n_wr, 5);

    // Accept and completion on the same edge: no overflow
    mem_ready = 1'b0;
    build_write(16'h0040, 2, 8'h90, 2);
    flush(1'b0, 11);
    wait_drain();
    chk("t4_err", err, 3'b000);
    chk("t4_writes", n_wr, 7);

    foreach (tbl[k]) send_cmd(tbl[k].b, tbl[k].err, tbl[k].st);
    send_cmd(8'hC3, 3'b000, 1'b0);

    // Reset mid-frame with a write pending
    mem_ready = 1'b0;
    build_write(16'h0020, 2, 8'h11, 0);
    while (txq.size() > 9) void'(txq.pop_back());
    flush(1'b0, -1);
    chk("t5_pend", mem_we, 1'b1);
    mon_en = 1'b0;
    @(negedge tck);
    aclr = 1'b0;
    #1;
    chk("t5_we", mem_we, 1'b0);
    chk("t5_busy", busy, 1'b0);
    chk("t5_addr", mem_addr, 16'h0);
    @(negedge tck);
    aclr      = 1'b1;
    mem_ready = 1'b1;
    @(negedge tck);
    mon_en = 1'b1;
    build_write(16'h0030, 1, 8'hDE, 1);
    flush(1'b1, -1);
    wait_drain();
    chk("t5_writes", n_wr, 8);

    // LEN=0 means 256 words; FSM must be back in IDLE afterwards
    build_write(16'h0100, 256, 8'h00, 256);
    flush(1'b1, -1);
    send_cmd(8'h5A, 3'b000, 1'b1);
    wait_drain();
    chk("t6_writes", n_wr, 264);

`ifdef JTAG_LOADER_CHECKSUM_EN
    txq = '{8'hA5, 8'h00, 8'h50, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h44};
    exp_q.push_back('{a: 16'h0050, d: 32'hDDCCBBAA});
    flush(1'b0, -1);
    wait_drain();
    chk("t7_bad_chk", err, 3'b100);
    send_cmd(8'hC3, 3'b000, 1'b0);
    txq = '{8'hA5, 8'h00, 8'h51, 8'h01, 8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'h00};
    exp_q.push_back('{a: 16'h0051, d: 32'hDDCCBBAA});
    flush(1'b0, -1);
    wait_drain();
    chk("t7_good_chk", err, 3'b000);
`endif

    chk("final_queue_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
